// File: rtl/dds_sweep_ctrl.sv
// Sweep controller for the DDS output stage: steps a 24-bit divider value
// from start to stop (up or down) holding each value for a programmable
// number of clk_400M cycles, in single-shot or continuous mode.
module dds_sweep_ctrl #(
  parameter logic [23:0] RESET_COUNT = 24'd99
) (
  input  logic        clk_400M,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [23:0] cfg_start,
  input  logic [23:0] cfg_stop,
  input  logic [23:0] cfg_step,
  input  logic [23:0] cfg_dwell,
  input  logic        cfg_loop,
  input  logic        abort,
  output logic [23:0] counter_out,
  output logic        busy,
  output logic        step_strobe,
  output logic        sweep_done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state;
  logic [23:0] start_reg;
  logic [23:0] stop_reg;
  logic [23:0] step_reg;      // already forced to at least 1
  logic [23:0] dwell_m1_reg;  // dwell_eff - 1, reload value of the dwell counter
  logic [23:0] dwell_cnt;
  logic        loop_reg;
  logic        dir_up_reg;

  // Zero step/dwell behave as 1
  logic [23:0] step_eff_in;
  logic [23:0] dwell_m1_in;
  assign step_eff_in = (cfg_step == 24'd0) ? 24'd1 : cfg_step;
  assign dwell_m1_in = (cfg_dwell == 24'd0) ? 24'd0 : cfg_dwell - 24'd1;

  // Next sweep value, computed one bit wider so overshoot is seen and clamped to stop
  logic [24:0] sum_up;
  logic [24:0] diff_dn;
  logic [23:0] next_val;
  assign sum_up  = {1'b0, counter_out} + {1'b0, step_reg};
  assign diff_dn = {1'b0, counter_out} - {1'b0, step_reg};

  // Select the clamped next value for the fixed sweep direction
  always_comb begin
    next_val = stop_reg;
    if (dir_up_reg) begin
      if (sum_up <= {1'b0, stop_reg}) next_val = sum_up[23:0];
    end else begin
      if (!diff_dn[24] && (diff_dn >= {1'b0, stop_reg})) next_val = diff_dn[23:0];
    end
  end

  // Sweep FSM with all outputs registered
  always_ff @(posedge clk_400M or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      counter_out  <= RESET_COUNT;
      dwell_cnt    <= 24'd0;
      busy         <= 1'b0;
      step_strobe  <= 1'b0;
      sweep_done   <= 1'b0;
      cfg_ready    <= 1'b0;
      start_reg    <= 24'd0;
      stop_reg     <= 24'd0;
      step_reg     <= 24'd1;
      dwell_m1_reg <= 24'd0;
      loop_reg     <= 1'b0;
      dir_up_reg   <= 1'b1;
    end else begin
      step_strobe <= 1'b0;
      sweep_done  <= 1'b0;
      case (state)
        IDLE: begin
          cfg_ready <= 1'b1;
          if (cfg_valid && cfg_ready) begin
            start_reg    <= cfg_start;
            stop_reg     <= cfg_stop;
            step_reg     <= step_eff_in;
            dwell_m1_reg <= dwell_m1_in;
            loop_reg     <= cfg_loop;
            dir_up_reg   <= (cfg_start <= cfg_stop);
            counter_out  <= cfg_start;
            dwell_cnt    <= dwell_m1_in;
            step_strobe  <= 1'b1;
            busy         <= 1'b1;
            cfg_ready    <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end else if (dwell_cnt != 24'd0) begin
            dwell_cnt <= dwell_cnt - 24'd1;
          end else if (counter_out != stop_reg) begin
            counter_out <= next_val;
            dwell_cnt   <= dwell_m1_reg;
            step_strobe <= 1'b1;
          end else if (loop_reg) begin
            counter_out <= start_reg;
            dwell_cnt   <= dwell_m1_reg;
            step_strobe <= 1'b1;
          end else begin
            busy       <= 1'b0;
            sweep_done <= 1'b1;
            state      <= FINISH;
          end
        end
        FINISH: begin
          // sweep_done is high for the single cycle spent here
          cfg_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          cfg_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
